// File: rtl/cpu_pkg.sv
// Shared datapath constants for the operand-fetch stage and its register file.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REG  = 8;
    localparam int ADDR_W   = $clog2(NUM_REG);
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_file.sv
// NREG x W register file: one write port, two read ports that bypass a
// same-cycle write-back; r0 always reads as zero.
module reg_file
    import cpu_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = NUM_REG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wbEn,
    input  logic [AW-1:0] wbAddr,
    input  logic [W-1:0]  wbData,
    input  logic [AW-1:0] rdAddrA,
    input  logic [AW-1:0] rdAddrB,
    output logic [W-1:0]  rdDataA,
    output logic [W-1:0]  rdDataB
);

    localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

    logic [W-1:0] regs [NREG];
    logic         wbLive;

    assign wbLive = wbEn && (wbAddr != ZeroAddr);

    // NOTE: the array is reset because architectural registers must read 0
    // after reset; this rules out a RAM macro, which is fine at this size.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wbLive) begin
            regs[wbAddr] <= wbData;
        end
    end

    // A write landing this edge is forwarded so the reader never sees stale data.
    assign rdDataA = (rdAddrA == ZeroAddr)                ? '0     :
                     (wbLive && (wbAddr == rdAddrA))      ? wbData :
                                                            regs[rdAddrA];
    assign rdDataB = (rdAddrB == ZeroAddr)                ? '0     :
                     (wbLive && (wbAddr == rdAddrB))      ? wbData :
                                                            regs[rdAddrB];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads two bypassed sources on a valid/ready handshake
// and holds them in an output register feeding the adder stage.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = NUM_REG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rs_a,
    input  logic [AW-1:0] rs_b,
    input  logic [AW-1:0] rd,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  op_a,
    output logic [W-1:0]  op_b,
    output logic [AW-1:0] out_rd,
    output logic [7:0]    issue_cnt
);

    logic [W-1:0]  readA;
    logic [W-1:0]  readB;
    logic          accept;
    logic          validQ;
    logic [W-1:0]  opAQ;
    logic [W-1:0]  opBQ;
    logic [AW-1:0] rdQ;
    logic [7:0]    issueCntQ;

    reg_file #(
        .W    (W),
        .NREG (NREG),
        .AW   (AW)
    ) uRegFile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wbEn    (wb_en),
        .wbAddr  (wb_addr),
        .wbData  (wb_data),
        .rdAddrA (rs_a),
        .rdAddrB (rs_b),
        .rdDataA (readA),
        .rdDataB (readB)
    );

    // The output slot is free when empty or being drained this cycle.
    assign in_ready = !validQ || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ    <= 1'b0;
            opAQ      <= '0;
            opBQ      <= '0;
            rdQ       <= '0;
            issueCntQ <= '0;
        end else if (accept) begin
            validQ    <= 1'b1;
            opAQ      <= readA;
            opBQ      <= readB;
            rdQ       <= rd;
            issueCntQ <= issueCntQ + 8'd1;
        end else if (out_ready) begin
            validQ    <= 1'b0;
        end
    end

    assign out_valid = validQ;
    assign op_a      = opAQ;
    assign op_b      = opBQ;
    assign out_rd    = rdQ;
    assign issue_cnt = issueCntQ;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random traffic
// compared against a transaction-level model of the register file and output slot.
module tb_operand_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] rs_a;
    logic [2:0] rs_b;
    logic [2:0] rd;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] out_rd;
    logic [7:0] issue_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: architectural registers and the single output slot.
    logic [7:0] mMem [8];
    logic       mValid;
    logic [7:0] mA;
    logic [7:0] mB;
    logic [2:0] mRd;
    logic [7:0] mCnt;

    operand_fetch #(.W(8), .NREG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs_a      (rs_a),
        .rs_b      (rs_b),
        .rd        (rd),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_rd    (out_rd),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] modelRead(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (wb_en && wb_addr == a) return wb_data;
        return mMem[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mMem[i] = 8'h00;
        mValid = 1'b0;
        mA     = 8'h00;
        mB     = 8'h00;
        mRd    = 3'd0;
        mCnt   = 8'h00;
    endtask

    task automatic checkOutputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
        check({tag, ".op_a"},      32'(op_a),      32'(mA));
        check({tag, ".op_b"},      32'(op_b),      32'(mB));
        check({tag, ".out_rd"},    32'(out_rd),    32'(mRd));
        check({tag, ".issue_cnt"}, 32'(issue_cnt), 32'(mCnt));
    endtask

    // One clock: drive at the falling edge, check in_ready, step the model,
    // then check registered outputs just after the rising edge.
    task automatic cycle(input string tag, input logic iv, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [2:0] rdd, input logic we,
                         input logic [2:0] wa, input logic [7:0] wd, input logic ordy);
        logic acc;
        in_valid  = iv;
        rs_a      = ra;
        rs_b      = rb;
        rd        = rdd;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        out_ready = ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!mValid || ordy));
        acc = iv && (!mValid || ordy);
        if (acc) begin
            mA     = modelRead(ra);
            mB     = modelRead(rb);
            mRd    = rdd;
            mValid = 1'b1;
            mCnt   = mCnt + 8'd1;
        end else if (ordy) begin
            mValid = 1'b0;
        end
        if (we && wa != 3'd0) mMem[wa] = wd;
        @(posedge clk);
        #1;
        checkOutputs(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic resetPulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rst_cnt"},   32'(issue_cnt), 32'd0);
        check({tag, ".rst_op_a"},  32'(op_a),      32'd0);
        check({tag, ".rst_op_b"},  32'(op_b),      32'd0);
        check({tag, ".rst_rd"},    32'(out_rd),    32'd0);
        check({tag, ".rst_ready"}, 32'(in_ready),  32'd1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rs_a      = 3'd0;
        rs_b      = 3'd0;
        rd        = 3'd0;
        wb_en     = 1'b0;
        wb_addr   = 3'd0;
        wb_data   = 8'h00;
        out_ready = 1'b0;
        modelReset();
        #1;
        check("por.out_valid", 32'(out_valid), 32'd0);
        check("por.issue_cnt", 32'(issue_cnt), 32'd0);
        check("por.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        idle("idle0");
        idle("idle1");

        // Plain read after write
        cycle("wr_r3", 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd3, 8'h2A, 1'b1);
        cycle("rd_r3", 1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b1);
        check("rd_r3.op_a_const", 32'(op_a), 32'h2A);
        check("rd_r3.op_b_const", 32'(op_b), 32'h00);
        check("rd_r3.valid_const", 32'(out_valid), 32'd1);

        // Same-cycle write-back bypass on both ports
        cycle("bypass", 1'b1, 3'd5, 3'd5, 3'd2, 1'b1, 3'd5, 8'h7F, 1'b1);
        check("bypass.op_a_const", 32'(op_a), 32'h7F);
        check("bypass.op_b_const", 32'(op_b), 32'h7F);

        // Stall: outputs hold while r3 is rewritten, second request waits
        cycle("stall_acc", 1'b1, 3'd3, 3'd4, 3'd6, 1'b0, 3'd0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 3'd3, 3'd3, 3'd7, (i == 1), 3'd3, 8'h55, 1'b0);
            check("stall.op_a_hold", 32'(op_a), 32'h2A);
            check("stall.in_ready_low", 32'(in_ready), 32'd0);
        end
        cycle("stall_release", 1'b1, 3'd3, 3'd3, 3'd7, 1'b0, 3'd0, 8'h00, 1'b1);
        check("stall_release.op_a_new", 32'(op_a), 32'h55);
        idle("drain0");

        // r0 is hard-wired to zero, including against same-cycle write-back
        cycle("wr_r0", 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b1);
        cycle("rd_r0", 1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 3'd0, 8'hFF, 1'b1);
        check("rd_r0.op_a_const", 32'(op_a), 32'h00);
        idle("drain1");

        // 257 back-to-back requests from a fresh reset: counter wraps to 1
        resetPulse("pre_stream");
        for (int i = 0; i < 257; i++) begin
            cycle("stream", 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 8'($urandom), 1'b1);
        end
        check("stream.wrap_const", 32'(issue_cnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cycle("stream2", 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'b1, 3'($urandom_range(0, 7)),
                  8'($urandom), 1'b1);
        end
        resetPulse("mid_stream");
        cycle("post_reset", 1'b1, 3'd3, 3'd5, 3'd4, 1'b0, 3'd0, 8'h00, 1'b0);

        // Random traffic with backpressure
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning datapath width in bits.
REQ-002 The block SHALL have parameter NREG, default 8, meaning register count; the address width SHALL be log2(NREG), which is 3 at default.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an upstream decode request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have ports rs_a and rs_b, input, 3 bits each: source register addresses.
REQ-008 The block SHALL have port rd, input, 3 bits: destination address, passed through to out_rd.
REQ-009 The block SHALL have port wb_en, input, 1 bit: write-back strobe from the adder result path.
REQ-010 The block SHALL have port wb_addr, input, 3 bits: write-back register address.
REQ-011 The block SHALL have port wb_data, input, W bits: write-back value, which is the adder sum S.
REQ-012 The block SHALL have port out_valid, output, 1 bit: op_a, op_b and out_rd are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream adder stage consumes the output.
REQ-014 The block SHALL have ports op_a and op_b, output, W bits each: operands driving adder inputs InA and InB.
REQ-015 The block SHALL have port out_rd, output, 3 bits: registered destination address.
REQ-016 The block SHALL have port issue_cnt, output, 8 bits: count of accepted requests.

Function
REQ-017 The register file SHALL be NREG x W; reading r0 SHALL return 0, and writes to r0 SHALL be ignored.
REQ-018 A write SHALL occur on any clock edge with wb_en=1 and wb_addr!=0, independent of handshake state.
REQ-019 in_ready SHALL be combinationally equal to (!out_valid || out_ready).
REQ-020 A request SHALL be accepted on an edge where in_valid && in_ready, and operands SHALL be captured with 1-cycle latency.
REQ-021 On acceptance, op_a SHALL capture the register rs_a, bypassed: if wb_en && wb_addr==rs_a && rs_a!=0, op_a SHALL take wb_data; op_b SHALL follow the same rule with rs_b.
REQ-022 On acceptance, out_rd SHALL capture rd, and out_valid SHALL be set to 1.
REQ-023 out_valid SHALL clear on an edge with out_ready=1 and no new acceptance on that edge.
REQ-024 On simultaneous consume and accept, out_valid SHALL stay 1 and the outputs SHALL take the new values (back-to-back throughput of 1 per cycle).
REQ-025 While out_valid && !out_ready (stall), op_a, op_b and out_rd SHALL hold; operands SHALL NOT be refreshed by later write-backs.
REQ-026 issue_cnt SHALL increment by 1 per acceptance and wrap from 255 to 0.
REQ-027 Outputs SHALL be driven only from flops, except in_ready.

Reset
REQ-028 While rst_n=0, all registers r1..r(NREG-1) SHALL be 0, out_valid=0, op_a=0, op_b=0, out_rd=0 and issue_cnt=0, asynchronously.
REQ-029 A reset asserted mid-transaction SHALL drop any pending output without a handshake; the first acceptance after deassertion SHALL behave as a fresh start.
REQ-030 in_ready SHALL read 1 during reset and in the first cycle after reset.

Structure
REQ-031 W, NREG, the address width and the zero-register index SHALL live in a shared package, cpu_pkg.
REQ-032 The register array with its write port and two bypassed read ports SHALL be one sub-module, reg_file; handshake, output register and counter SHALL stay in operand_fetch.

Verification
REQ-033 Reset then idle: all outputs SHALL read 0 and in_ready=1.
REQ-034 Write r3=0x2A, then request rs_a=3, rs_b=0 with out_ready=1: the next cycle SHALL show op_a=0x2A, op_b=0x00, out_valid=1.
REQ-035 Bypass: in the same cycle, wb_en=1, wb_addr=5, wb_data=0x7F, and a request with rs_a=5, rs_b=5: the output SHALL show op_a=op_b=0x7F.
REQ-036 Stall: out_ready=0 for 3 cycles while a write to the source register lands: the outputs SHALL hold their old values, in_ready=0, and a second request SHALL be held off until out_ready=1.
REQ-037 Write to r0 with 0xFF, then read r0: the result SHALL be 0x00.
REQ-038 Issue 257 back-to-back requests with out_ready=1: issue_cnt SHALL end at 1 (wrap), out_valid SHALL stay continuous, and an rst_n pulse mid-stream SHALL clear out_valid and issue_cnt immediately.
